usb_tx: RTL and testbench
=========================

USB_TX -- requirements
Module: usb_tx

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state on rising edge.
REQ-002 SHALL have port n_rst, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port tx_packet, input, 3, command: 0 NONE, 1 DATA0, 2 ACK, 3 NAK, 4 STALL, 5-7 invalid.
REQ-004 SHALL have port tx_packet_data, input, 8, next payload byte from the TX buffer, valid in the cycle get_tx_packet_data is high.
REQ-005 SHALL have port buffer_occupancy, input, 7, payload bytes available (0-64).
REQ-006 SHALL have port get_tx_packet_data, output, 1, one-cycle pop strobe to the TX buffer.
REQ-007 SHALL have port tx_transfer_active, output, 1, high while a packet is on the bus.
REQ-008 SHALL have port tx_error, output, 1, one-cycle pulse on rejected command.
REQ-009 SHALL have port dplus_out, output, 1, encoded D+.
REQ-010 SHALL have port dminus_out, output, 1, encoded D-.

Function
REQ-011 SHALL use a fixed bit period of 8 clk cycles; the line value changes only at bit-period boundaries.
REQ-012 SHALL drive idle J (dplus_out=1, dminus_out=0) whenever not transmitting.
REQ-013 SHALL NRZI-encode: bit 0 toggles both lines, bit 1 holds; bits go LSB first per byte.
REQ-014 SHALL implement states IDLE, SYNC, PID, DATA, CRC, EOP with transitions IDLE->SYNC->PID->{EOP for ACK/NAK/STALL, DATA for DATA0}, DATA->CRC->EOP->IDLE.
REQ-015 SHALL sample tx_packet only in IDLE; a value of 1-4 starts a packet, and the first SYNC bit appears on the lines at the next rising edge.
REQ-016 SHALL ignore tx_packet changes while a packet is in progress.
REQ-017 SHALL send SYNC as 8'h80 (seven 0s, then 1).
REQ-018 SHALL send PID bytes DATA0=8'hC3, ACK=8'hD2, NAK=8'h5A, STALL=8'h1E.
REQ-019 For DATA0, SHALL pop one byte (get_tx_packet_data for exactly 1 cycle) per byte slot while buffer_occupancy != 0, up to 64 bytes.
REQ-020 The pop SHALL occur no later than the last clk of the previous byte's final bit period.
REQ-021 SHALL go to CRC when buffer_occupancy == 0 at a byte boundary; occupancy 0 at PID end gives a zero-length packet.
REQ-022 SHALL compute CRC16 over payload bits only: poly 0x8005, init 16'hFFFF, reinitialised at each packet start.
REQ-023 SHALL transmit the complemented CRC, crc[15] first.
REQ-024 SHALL bit-stuff: after six consecutive 1s (pre-NRZI, counted from SYNC onward), insert one 0 bit; stuff bits are excluded from the CRC.
REQ-025 SHALL apply stuffing after the last CRC bit before EOP when required.
REQ-026 SHALL send EOP as SE0 (both lines 0) for 2 bit periods, then J for 1 bit period, then return to IDLE.
REQ-027 SHALL raise tx_transfer_active in the cycle the first SYNC bit is driven and hold it through the final EOP J bit; it deasserts at the first IDLE cycle.
REQ-028 A tx_packet value of 5-7 in IDLE SHALL pulse tx_error for 1 cycle, send nothing, and remain in IDLE.
REQ-029 A new command present in the first IDLE cycle SHALL be accepted, allowing back-to-back packets.
REQ-030 SHALL provide registered outputs with no combinational path from inputs to dplus_out/dminus_out.

Reset
REQ-031 n_rst low SHALL immediately set state IDLE, dplus_out=1, dminus_out=0, tx_transfer_active=0, get_tx_packet_data=0, tx_error=0, bit/byte/stuff counters=0, CRC=16'hFFFF.
REQ-032 Reset mid-packet SHALL abort with no EOP, and the lines SHALL go to J asynchronously.
REQ-033 After reset release, the block SHALL accept a command on the first IDLE edge.

Verification
REQ-034 ACK: tx_packet=2 for 1 cycle -> SYNC+8'hD2 NRZI waveform, then SE0 16 clks, J 8 clks; tx_transfer_active high exactly 152 clks.
REQ-035 Zero-length DATA0: occupancy=0, tx_packet=1 -> SYNC, 8'hC3, 16 zero CRC bits (toggle each bit), EOP; active 280 clks; no get_tx_packet_data.
REQ-036 DATA0 with one byte 8'hFF: stuff 0 inserted after the 4th payload bit (PID ends with two 1s); exactly one get_tx_packet_data pulse; CRC matches the reference model.
REQ-037 DATA0 with 64 bytes, occupancy held at 64 -> exactly 64 pops, then CRC, even though occupancy never reaches 0.
REQ-038 tx_packet=6 in IDLE -> tx_error 1-cycle pulse, lines remain J, tx_transfer_active stays 0.
REQ-039 n_rst asserted mid-DATA -> lines J in the same timestep, active=0; a subsequent NAK command is transmitted correctly.

Source files
------------

// File: rtl/usb_tx.sv
// USB full-speed style transmitter: serialises SYNC, PID, optional DATA0
// payload and CRC16 with bit stuffing and NRZI coding, then drives EOP.
// Every bit occupies a fixed 8-clock period on the D+/D- lines.
module usb_tx (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [2:0] tx_packet,
  input  logic [7:0] tx_packet_data,
  input  logic [6:0] buffer_occupancy,
  output logic       get_tx_packet_data,
  output logic       tx_transfer_active,
  output logic       tx_error,
  output logic       dplus_out,
  output logic       dminus_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC, S_EOP
  } state_t;

  localparam logic [2:0]  CMD_DATA0 = 3'd1;
  localparam logic [2:0]  CMD_ACK   = 3'd2;
  localparam logic [2:0]  CMD_NAK   = 3'd3;
  localparam logic [2:0]  CMD_STALL = 3'd4;
  localparam logic [6:0]  MAX_BYTES = 7'd64;
  localparam logic [15:0] CRC_INIT  = 16'hFFFF;

  state_t      state_reg, state_next;
  logic [2:0]  timer_reg, timer_next;        // clock within the bit period
  logic [3:0]  bit_idx_reg, bit_idx_next;    // bit within the current field
  logic [2:0]  ones_reg, ones_next;          // consecutive 1s sent
  logic [7:0]  shift_reg, shift_next;        // remaining bits of current byte
  logic [15:0] crc_reg, crc_next;
  logic [2:0]  cmd_reg, cmd_next;
  logic [7:0]  next_byte_reg, next_byte_next;
  logic        have_byte_reg, have_byte_next;
  logic [6:0]  byte_cnt_reg, byte_cnt_next;
  logic        get_reg, get_next;
  logic        err_reg, err_next;
  logic        active_reg, active_next;
  logic        dp_reg, dp_next;
  logic        dm_reg, dm_next;

  logic        boundary, stuff_state, stuff_now, advance, field_done;
  logic        start_cmd, bad_cmd, wants_payload, pop_now;
  logic [3:0]  last_idx;
  logic [7:0]  pid_byte;
  logic        emit_en, emit_bit, crc_en;

  // One CRC16 (poly 0x8005) step for a single payload bit.
  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic din);
    crc_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? 16'h8005 : 16'h0000);
  endfunction

  // Field decode shared by the next-state and datapath logic.
  always_comb begin
    boundary      = (state_reg != S_IDLE) && (timer_reg == 3'd7);
    stuff_state   = (state_reg == S_SYNC) || (state_reg == S_PID) ||
                    (state_reg == S_DATA) || (state_reg == S_CRC);
    stuff_now     = boundary && stuff_state && (ones_reg == 3'd6);
    advance       = boundary && !stuff_now;
    case (state_reg)
      S_CRC:   last_idx = 4'd15;
      S_EOP:   last_idx = 4'd2;
      default: last_idx = 4'd7;
    endcase
    field_done    = (bit_idx_reg == last_idx);
    start_cmd     = (state_reg == S_IDLE) && (tx_packet >= CMD_DATA0) && (tx_packet <= CMD_STALL);
    bad_cmd       = (state_reg == S_IDLE) && (tx_packet > CMD_STALL);
    wants_payload = (state_reg == S_DATA) || ((state_reg == S_PID) && (cmd_reg == CMD_DATA0));
    // Pop during the final bit of a byte so the data is held before the boundary.
    pop_now       = wants_payload && (timer_reg == 3'd5) && (bit_idx_reg == 4'd7) &&
                    !have_byte_reg && !get_reg && (buffer_occupancy != 7'd0) &&
                    (byte_cnt_reg < MAX_BYTES);
    case (cmd_reg)
      CMD_DATA0: pid_byte = 8'hC3;
      CMD_ACK:   pid_byte = 8'hD2;
      CMD_NAK:   pid_byte = 8'h5A;
      CMD_STALL: pid_byte = 8'h1E;
      default:   pid_byte = 8'h00;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: fields advance only at non-stuff bit boundaries.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (start_cmd) state_next = S_SYNC;
      S_SYNC: if (advance && field_done) state_next = S_PID;
      S_PID:  if (advance && field_done) begin
                if (cmd_reg == CMD_DATA0) state_next = have_byte_reg ? S_DATA : S_CRC;
                else                      state_next = S_EOP;
              end
      S_DATA: if (advance && field_done) state_next = have_byte_reg ? S_DATA : S_CRC;
      S_CRC:  if (advance && field_done) state_next = S_EOP;
      S_EOP:  if (boundary && field_done) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output/datapath logic: choose the next line symbol and update counters.
  always_comb begin
    timer_next     = (state_reg == S_IDLE) ? 3'd0 : timer_reg + 3'd1;
    bit_idx_next   = bit_idx_reg;
    ones_next      = ones_reg;
    shift_next     = shift_reg;
    crc_next       = crc_reg;
    cmd_next       = cmd_reg;
    next_byte_next = next_byte_reg;
    have_byte_next = have_byte_reg;
    byte_cnt_next  = byte_cnt_reg;
    get_next       = pop_now;
    err_next       = 1'b0;
    active_next    = active_reg;
    dp_next        = dp_reg;
    dm_next        = dm_reg;
    emit_en        = 1'b0;
    emit_bit       = 1'b0;
    crc_en         = 1'b0;

    if (get_reg) begin
      next_byte_next = tx_packet_data;
      have_byte_next = 1'b1;
      byte_cnt_next  = byte_cnt_reg + 7'd1;
    end

    case (state_reg)
      S_IDLE: begin
        if (start_cmd) begin
          active_next    = 1'b1;
          cmd_next       = tx_packet;
          crc_next       = CRC_INIT;
          byte_cnt_next  = 7'd0;
          have_byte_next = 1'b0;
          bit_idx_next   = 4'd0;
          ones_next      = 3'd0;
          shift_next     = 8'h40;   // SYNC 8'h80 with its first bit consumed
          emit_en        = 1'b1;
          emit_bit       = 1'b0;
        end else if (bad_cmd) begin
          err_next = 1'b1;
        end
      end
      S_EOP: begin
        if (boundary) begin
          if (field_done) begin
            active_next  = 1'b0;
            bit_idx_next = 4'd0;
            dp_next      = 1'b1;
            dm_next      = 1'b0;
          end else begin
            bit_idx_next = bit_idx_reg + 4'd1;
            if (bit_idx_reg == 4'd1) begin
              dp_next = 1'b1;
              dm_next = 1'b0;
            end
          end
        end
      end
      default: begin
        if (stuff_now) begin
          emit_en  = 1'b1;
          emit_bit = 1'b0;
        end else if (advance && !field_done) begin
          bit_idx_next = bit_idx_reg + 4'd1;
          emit_en      = 1'b1;
          if (state_reg == S_CRC) begin
            emit_bit = ~crc_reg[15];
            crc_next = {crc_reg[14:0], 1'b0};
          end else begin
            emit_bit   = shift_reg[0];
            shift_next = {1'b0, shift_reg[7:1]};
            crc_en     = (state_reg == S_DATA);
          end
        end else if (advance) begin
          bit_idx_next = 4'd0;
          case (state_next)
            S_PID: begin
              emit_en    = 1'b1;
              emit_bit   = pid_byte[0];
              shift_next = {1'b0, pid_byte[7:1]};
            end
            S_DATA: begin
              emit_en        = 1'b1;
              emit_bit       = next_byte_reg[0];
              shift_next     = {1'b0, next_byte_reg[7:1]};
              have_byte_next = 1'b0;
              crc_en         = 1'b1;
            end
            S_CRC: begin
              emit_en  = 1'b1;
              emit_bit = ~crc_reg[15];
              crc_next = {crc_reg[14:0], 1'b0};
            end
            default: begin  // EOP: start SE0
              ones_next = 3'd0;
              dp_next   = 1'b0;
              dm_next   = 1'b0;
            end
          endcase
        end
      end
    endcase

    if (emit_en) begin
      if (!emit_bit) begin
        dp_next = ~dp_reg;
        dm_next = ~dm_reg;
      end
      ones_next = emit_bit ? ones_reg + 3'd1 : 3'd0;
    end
    if (crc_en) crc_next = crc_step(crc_reg, emit_bit);
  end

  // Datapath and output registers; reset parks the lines at J immediately.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      timer_reg     <= 3'd0;
      bit_idx_reg   <= 4'd0;
      ones_reg      <= 3'd0;
      shift_reg     <= 8'h00;
      crc_reg       <= CRC_INIT;
      cmd_reg       <= 3'd0;
      next_byte_reg <= 8'h00;
      have_byte_reg <= 1'b0;
      byte_cnt_reg  <= 7'd0;
      get_reg       <= 1'b0;
      err_reg       <= 1'b0;
      active_reg    <= 1'b0;
      dp_reg        <= 1'b1;
      dm_reg        <= 1'b0;
    end else begin
      timer_reg     <= timer_next;
      bit_idx_reg   <= bit_idx_next;
      ones_reg      <= ones_next;
      shift_reg     <= shift_next;
      crc_reg       <= crc_next;
      cmd_reg       <= cmd_next;
      next_byte_reg <= next_byte_next;
      have_byte_reg <= have_byte_next;
      byte_cnt_reg  <= byte_cnt_next;
      get_reg       <= get_next;
      err_reg       <= err_next;
      active_reg    <= active_next;
      dp_reg        <= dp_next;
      dm_reg        <= dm_next;
    end
  end

  assign get_tx_packet_data = get_reg;
  assign tx_transfer_active = active_reg;
  assign tx_error           = err_reg;
  assign dplus_out          = dp_reg;
  assign dminus_out         = dm_reg;

endmodule

// File: tb/tb_usb_tx.sv
// Self-checking bench for usb_tx: expected line waveforms are built from a
// bit-level packet model (bytes -> CRC -> stuffing -> NRZI -> 8 clocks/bit).
module tb_usb_tx;

  logic       tb_clk = 1'b0;
  logic       n_rst;
  logic [2:0] tx_packet;
  logic [7:0] tx_packet_data;
  logic [6:0] buffer_occupancy;
  logic       get_tx_packet_data;
  logic       tx_transfer_active;
  logic       tx_error;
  logic       dplus_out;
  logic       dminus_out;

  usb_tx dut (
    .clk                (tb_clk),
    .n_rst              (n_rst),
    .tx_packet          (tx_packet),
    .tx_packet_data     (tx_packet_data),
    .buffer_occupancy   (buffer_occupancy),
    .get_tx_packet_data (get_tx_packet_data),
    .tx_transfer_active (tx_transfer_active),
    .tx_error           (tx_error),
    .dplus_out          (dplus_out),
    .dminus_out         (dminus_out)
  );

  always #5 tb_clk = ~tb_clk;

  int         checks_total  = 0;
  int         checks_passed = 0;
  logic [7:0] payload [0:79];
  int         pop_idx = 0;
  logic       pop_pend = 1'b0;
  int         pop_cnt = 0;
  int         err_cnt = 0;
  logic       hold_occ = 1'b0;
  bit         exp_bits[$];
  logic [1:0] exp_sym[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock, sample just after the edge, and model the TX buffer.
  task automatic tick();
    @(posedge tb_clk);
    #1;
    if (pop_pend) begin
      pop_idx++;
      if (!hold_occ && buffer_occupancy != 7'd0) buffer_occupancy--;
    end
    tx_packet_data = payload[pop_idx % 80];
    pop_pend = get_tx_packet_data;
    if (get_tx_packet_data) pop_cnt++;
    if (tx_error) err_cnt++;
  endtask

  function automatic logic [15:0] crc16(input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++) begin
        fb = c[15] ^ payload[i][b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    return c;
  endfunction

  task automatic add_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
  endtask

  // Expected per-bit-period line symbols {D+,D-} for one packet.
  task automatic build_expected(input logic [2:0] cmd, input int nbytes);
    logic [7:0]  pid;
    logic [15:0] c;
    logic [1:0]  level;
    int          run;
    exp_bits.delete();
    exp_sym.delete();
    case (cmd)
      3'd1:    pid = 8'hC3;
      3'd2:    pid = 8'hD2;
      3'd3:    pid = 8'h5A;
      default: pid = 8'h1E;
    endcase
    add_byte(8'h80);
    add_byte(pid);
    if (cmd == 3'd1) begin
      for (int i = 0; i < nbytes; i++) add_byte(payload[i]);
      c = ~crc16(nbytes);
      for (int i = 15; i >= 0; i--) exp_bits.push_back(c[i]);
    end
    level = 2'b10;
    run   = 0;
    foreach (exp_bits[i]) begin
      if (!exp_bits[i]) level = ~level;
      exp_sym.push_back(level);
      run = exp_bits[i] ? run + 1 : 0;
      if (run == 6) begin
        level = ~level;
        exp_sym.push_back(level);
        run = 0;
      end
    end
    exp_sym.push_back(2'b00);
    exp_sym.push_back(2'b00);
    exp_sym.push_back(2'b10);
  endtask

  task automatic fill_payload(input int ff_bias);
    for (int i = 0; i < 80; i++)
      payload[i] = ($urandom_range(0, 99) < ff_bias) ? 8'hFF : 8'($urandom);
  endtask

  // Issue one command and compare the whole packet, one check per bit period.
  task automatic send_packet(input string tag, input logic [2:0] cmd, input int occ,
                             input logic hold, input logic junk);
    int nbytes;
    int act_cnt;
    int nsym;
    logic [15:0] obs_w, exp_w;
    nbytes = (cmd == 3'd1) ? ((occ > 64) ? 64 : occ) : 0;
    build_expected(cmd, nbytes);
    nsym             = exp_sym.size();
    buffer_occupancy = 7'(occ);
    hold_occ         = hold;
    pop_idx          = 0;
    pop_pend         = 1'b0;
    pop_cnt          = 0;
    err_cnt          = 0;
    act_cnt          = 0;
    tx_packet_data   = payload[0];
    tx_packet        = cmd;
    tick();
    for (int s = 0; s < nsym; s++) begin
      obs_w = 16'h0;
      exp_w = 16'h0;
      for (int k = 0; k < 8; k++) begin
        obs_w = {obs_w[13:0], dplus_out, dminus_out};
        exp_w = {exp_w[13:0], exp_sym[s]};
        if (tx_transfer_active) act_cnt++;
        tx_packet = junk ? 3'($urandom) : 3'd0;
        tick();
      end
      check($sformatf("%s bit%0d", tag, s), 32'(obs_w), 32'(exp_w));
    end
    tx_packet = 3'd0;
    check($sformatf("%s active_clks", tag), 32'(act_cnt), 32'(nsym * 8));
    check($sformatf("%s pops", tag), 32'(pop_cnt), 32'(nbytes));
    check($sformatf("%s no_error", tag), 32'(err_cnt), 32'd0);
    check($sformatf("%s idle_after", tag),
          {29'd0, tx_transfer_active, dplus_out, dminus_out}, 32'b010);
    $display("packet %s cmd=%0d bytes=%0d bit_periods=%0d", tag, cmd, nbytes, nsym);
  endtask

  initial begin
    n_rst            = 1'b0;
    tx_packet        = 3'd0;
    tx_packet_data   = 8'h00;
    buffer_occupancy = 7'd0;
    fill_payload(0);
    repeat (3) @(negedge tb_clk);
    check("reset_state",
          {27'd0, dplus_out, dminus_out, tx_transfer_active, get_tx_packet_data, tx_error},
          32'b10000);
    n_rst = 1'b1;

    send_packet("ack", 3'd2, 0, 1'b0, 1'b1);
    send_packet("data0_zero_len", 3'd1, 0, 1'b0, 1'b0);
    fill_payload(0);
    payload[0] = 8'hFF;
    send_packet("data0_ff", 3'd1, 1, 1'b0, 1'b0);
    fill_payload(20);
    send_packet("data0_held64", 3'd1, 64, 1'b1, 1'b0);

    tx_packet = 3'd6;
    tick();
    check("error_pulse",
          {28'd0, tx_error, dplus_out, dminus_out, tx_transfer_active}, 32'b1100);
    tx_packet = 3'd0;
    tick();
    check("error_cleared",
          {28'd0, tx_error, dplus_out, dminus_out, tx_transfer_active}, 32'b0100);
    $display("error command: tx_packet=6 rejected");

    for (int r = 0; r < 8; r++) begin
      fill_payload(35);
      send_packet($sformatf("rand%0d", r), 3'($urandom_range(1, 4)),
                  $urandom_range(0, 12), 1'b0, 1'b1);
    end
    send_packet("stall", 3'd4, 0, 1'b0, 1'b0);

    // Abort a DATA0 packet mid-payload, then send NAK straight after reset.
    fill_payload(0);
    buffer_occupancy = 7'd10;
    hold_occ         = 1'b0;
    pop_idx          = 0;
    pop_pend         = 1'b0;
    tx_packet        = 3'd1;
    tick();
    tx_packet = 3'd0;
    repeat (150) tick();
    #2 n_rst = 1'b0;
    #1;
    check("abort_lines",
          {28'd0, dplus_out, dminus_out, tx_transfer_active, get_tx_packet_data}, 32'b1000);
    $display("reset asserted mid-DATA");
    @(negedge tb_clk);
    n_rst    = 1'b1;
    pop_pend = 1'b0;
    send_packet("nak_after_reset", 3'd3, 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
